// File: rtl/commit_trace_tx.sv
// Commit-trace transmit FIFO: compacts per-cycle retire events (commits + one trap)
// into an ordered queue and drains one record per cycle over a valid/ready link.

module commit_trace_lane #(
  parameter int PW = 4,
  parameter int NW = 2
) (
  input  logic          valid,
  input  logic [NW-1:0] off_in,
  input  logic [PW-1:0] wr_ptr,
  output logic [NW-1:0] off_out,
  output logic [PW-1:0] idx
);
  // Running count of valid lanes below this one gives the compacted slot.
  assign off_out = off_in + NW'(valid);
  assign idx     = wr_ptr + PW'(off_in);
endmodule

module commit_trace_tx #(
  parameter int COMMIT_WIDTH = 1,
  parameter int XLEN         = 64,
  parameter int INST_BITS    = 32,
  parameter int HARTID_LEN   = 1,
  parameter int DEPTH        = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [HARTID_LEN-1:0]          hartid,
  input  logic [COMMIT_WIDTH-1:0]        in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0]   in_pc,
  input  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0]   in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0]   in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]        in_check,
  input  logic                           in_int_xcpt,
  input  logic [XLEN-1:0]                in_cause,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_is_trap,
  output logic [HARTID_LEN-1:0]          out_hartid,
  output logic [XLEN-1:0]                out_pc,
  output logic [INST_BITS-1:0]           out_inst,
  output logic [XLEN-1:0]                out_wdata,
  output logic [XLEN-1:0]                out_mstatus,
  output logic                           out_check,
  output logic [XLEN-1:0]                out_cause,
  output logic                           almost_full,
  output logic                           overflow,
  output logic [$clog2(DEPTH):0]         occupancy
);
  localparam int PW    = $clog2(DEPTH);
  localparam int OW    = PW + 1;
  localparam int FW    = OW + 1;
  localparam int NW    = $clog2(COMMIT_WIDTH + 2);
  localparam int AF_TH = DEPTH - 2 * (COMMIT_WIDTH + 1);

  typedef struct packed {
    logic                 is_trap;
    logic [XLEN-1:0]      pc;
    logic [INST_BITS-1:0] inst;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      mstatus;
    logic                 check;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t head;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ, occ_next;
  logic [COMMIT_WIDTH:0][NW-1:0]   off;
  logic [COMMIT_WIDTH-1:0][PW-1:0] lane_idx;
  logic [PW-1:0] trap_idx;
  logic [NW-1:0] n;
  logic [FW-1:0] free;
  logic          pop, fits;

  assign off[0] = '0;

  for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_lane
    commit_trace_lane #(.PW(PW), .NW(NW)) u_lane (
      .valid  (in_valid[i]),
      .off_in (off[i]),
      .wr_ptr (wr_ptr),
      .off_out(off[i+1]),
      .idx    (lane_idx[i])
    );
  end

  assign trap_idx = wr_ptr + PW'(off[COMMIT_WIDTH]);
  assign n        = off[COMMIT_WIDTH] + NW'(in_int_xcpt);
  assign pop      = out_valid & out_ready;
  // The slot freed by this cycle's pop is usable by this cycle's batch.
  assign free     = FW'(DEPTH) - FW'(occ) + FW'(pop);
  assign fits     = FW'(n) <= free;
  assign occ_next = occ + (fits ? OW'(n) : '0) - OW'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + (fits ? PW'(n) : '0);
      rd_ptr      <= rd_ptr + PW'(pop);
      occ         <= occ_next;
      almost_full <= occ_next > OW'(AF_TH);
      if (!fits) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (!reset && fits) begin
      for (int i = 0; i < COMMIT_WIDTH; i++)
        if (in_valid[i])
          mem[lane_idx[i]] <= '{1'b0, in_pc[i*XLEN +: XLEN], in_inst[i*INST_BITS +: INST_BITS],
                                in_wdata[i*XLEN +: XLEN], in_mstatus[i*XLEN +: XLEN], in_check[i]};
      if (in_int_xcpt)
        mem[trap_idx] <= '{1'b1, '0, '0, in_cause, '0, 1'b0};
    end
  end

  assign head        = mem[rd_ptr];
  assign out_valid   = occ != '0;
  assign occupancy   = occ;
  assign out_is_trap = head.is_trap;
  assign out_hartid  = hartid;
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_wdata   = head.wdata;
  assign out_mstatus = head.mstatus;
  assign out_check   = head.check;
  assign out_cause   = head.is_trap ? head.wdata : '0;

endmodule
